agu_context_sequencer: RTL and testbench
========================================

// Module: agu_context_sequencer
// PURPOSE
//  Generates the context pointer CP that indexes the AGU context cache once configuration load is
//  complete (start=1), and registers the returned context word for the AGU datapath.
//  Walks the context range base_cp..last_cp, repeating it iter_cnt times, with stall and abort support.
//  Sits directly downstream of the context cache: drives its CP input, consumes its outdata.
// PARAMETERS
//  CTX_W   29  context word width (cache width parameter + 1)
//  CP_W    16  width of CP port into cache
//  ADDR_W  6   used context address bits (64-entry cache); CP[CP_W-1:ADDR_W] always 0
//  ITER_W  16  iteration counter width
// PORTS
//  CLK        in   1       clock, all state updates on rising edge
//  RST_N      in   1       synchronous active-low reset
//  start      in   1       0 = cache loading phase, 1 = run phase (same signal as cache start)
//  run_req    in   1       request to start a sequence; sampled in IDLE only
//  base_cp    in   ADDR_W  first context index of range
//  last_cp    in   ADDR_W  last context index of range (inclusive)
//  iter_cnt   in   ITER_W  range repetitions; 0 treated as 1
//  stall      in   1       downstream not ready; freeze sequencing
//  ctx_in     in   CTX_W   context word from cache (combinational read of data_table[CP])
//  CP         out  CP_W    context pointer to cache
//  ctx_out    out  CTX_W   registered context word
//  ctx_valid  out  1       ctx_out holds a new word this cycle
//  busy       out  1       high in RUN
//  done       out  1       one-cycle pulse, sequence completed normally
//  err        out  1       one-cycle pulse, run_req rejected (last_cp < base_cp)
//  abort      out  1       one-cycle pulse, start fell to 0 during RUN
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): state IDLE; CP=0, ctx_out=0, ctx_valid=0, busy=0, done=err=abort=0.
//  - States: IDLE, RUN, DONE. All outputs registered.
//  - IDLE: run_req=1 & start=1 & last_cp>=base_cp -> latch base/last, iter_left=max(iter_cnt,1),
//    CP<=base_cp, -> RUN. run_req=1 & last_cp<base_cp -> err pulse next cycle, stay IDLE.
//    run_req with start=0 ignored. ctx_valid=0.
//  - RUN, stall=0: ctx_out<=ctx_in, ctx_valid<=1. If CP!=last: CP<=CP+1. If CP==last and
//    iter_left>1: CP<=base, iter_left--. If CP==last and iter_left==1: -> DONE, CP holds.
//  - RUN, stall=1: CP, ctx_out, iter_left hold; ctx_valid<=0. Stall has no effect outside RUN.
//  - Latency: run_req accepted at edge k -> CP=base in cycle k+1 -> first ctx_valid in cycle k+2.
//    One word per unstalled cycle; total words = (last-base+1)*max(iter_cnt,1).
//  - DONE: done=1 for exactly one cycle, coincident with ctx_valid of the final word; -> IDLE.
//  - run_req while in RUN/DONE ignored (not queued).
//  - start=0 sampled in RUN (overrides stall): -> IDLE, abort pulse next cycle, ctx_valid<=0,
//    CP<=0, no done. start=0 in DONE: done still issued.
//  - Single-entry range (base==last) legal: CP constant, word repeated iter times.
//  - CP arithmetic in ADDR_W bits, zero-extended to CP_W; CP never exceeds last_cp (no 63->0 wrap).
//  - Reset mid-RUN: immediate return to IDLE, all outputs to reset values, no done/abort pulse.
// STRUCTURE
//  - Shared package agu_pkg: CTX_W, ADDR_W, CP_W, ITER_W constants; seq_state_t enum {IDLE,RUN,DONE}.
//  - One sub-module: agu_iter_counter (loadable down-counter, zero->1 clamp, is_last flag).
//  - Context cache not instantiated here; bench instantiates cache + sequencer together.
// TESTING
//  - Preload cache entries 0..63 with value=index*3; run base=4,last=7,iter=2 -> ctx_out sequence
//    12,15,18,21,12,15,18,21, first valid 2 cycles after run_req, done with word 21 (2nd pass).
//  - Reset: RST_N=0 for 2 cycles mid-RUN -> all outputs 0 next cycle, no done/abort pulse.
//  - base=10,last=10,iter=0 -> single word 30, done same cycle, CP=10 throughout.
//  - base=9,last=3 -> err pulse 1 cycle, busy stays 0, CP unchanged.
//  - base=0,last=3,iter=1 with stall high 3 cycles after 2nd word -> CP held at 2, ctx_valid low
//    3 cycles, then words 6,9, done.
//  - start dropped to 0 after 2nd word of base=20,last=30 -> abort pulse, CP=0, no done;
//    new run_req with start=0 ignored; with start=1 accepted normally.

Source files
------------

// File: rtl/agu_context_sequencer_pkg.sv
// Shared constants and types for the AGU context sequencer.
// The context cache width sets CtxW, and the 64-entry cache sets AddrW.
package agu_context_sequencer_pkg;

  localparam int unsigned CtxW  = 29;
  localparam int unsigned CpW   = 16;
  localparam int unsigned AddrW = 6;
  localparam int unsigned IterW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_t;

  // A repetition count of zero runs the range once.
  function automatic logic [IterW-1:0] clamp_iter(input logic [IterW-1:0] n);
    return (n == '0) ? IterW'(1) : n;
  endfunction

endpackage

// File: rtl/agu_context_sequencer_if.sv
// Control and data bundle between the run controller, the context cache and the sequencer.
// The sequencer uses the slave modport, and the controller or bench side uses master.
interface agu_context_sequencer_if;
  import agu_context_sequencer_pkg::*;

  logic             start;
  logic             run_req;
  logic [AddrW-1:0] base_cp;
  logic [AddrW-1:0] last_cp;
  logic [IterW-1:0] iter_cnt;
  logic             stall;
  logic [CtxW-1:0]  ctx_in;
  logic [CpW-1:0]   CP;
  logic [CtxW-1:0]  ctx_out;
  logic             ctx_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic             abort;

  modport master (
    output start, run_req, base_cp, last_cp, iter_cnt, stall, ctx_in,
    input  CP, ctx_out, ctx_valid, busy, done, err, abort
  );

  modport slave (
    input  start, run_req, base_cp, last_cp, iter_cnt, stall, ctx_in,
    output CP, ctx_out, ctx_valid, busy, done, err, abort
  );

endinterface

// File: rtl/agu_context_sequencer_iter_counter.sv
// Loadable down-counter that tracks the remaining range repetitions.
// A load value of zero is stored as 1, and the counter never decrements below 1.
module agu_context_sequencer_iter_counter
  import agu_context_sequencer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [IterW-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_last_o
);

  logic [IterW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = clamp_iter(load_val_i);
    end else if (dec_i && (cnt_q > IterW'(1))) begin
      cnt_d = cnt_q - IterW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_last_o = (cnt_q == IterW'(1));

endmodule

// File: rtl/agu_context_sequencer.sv
// Walks the context pointer over base..last for a set number of passes.
// Registers the word that the cache returns for each pointer into ctx_out.
module agu_context_sequencer
  import agu_context_sequencer_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RST_N,
  agu_context_sequencer_if.slave        bus
);

  seq_state_t       state_d, state_q;
  logic [AddrW-1:0] cp_d, cp_q;
  logic [AddrW-1:0] base_d, base_q;
  logic [AddrW-1:0] last_d, last_q;
  logic [CtxW-1:0]  ctx_out_d, ctx_out_q;
  logic             valid_d, valid_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             err_d, err_q;
  logic             abort_d, abort_q;
  logic             iter_load, iter_dec, iter_last;

  agu_context_sequencer_iter_counter u_iter (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (iter_load),
    .load_val_i (bus.iter_cnt),
    .dec_i      (iter_dec),
    .is_last_o  (iter_last)
  );

  always_comb begin
    state_d   = state_q;
    cp_d      = cp_q;
    base_d    = base_q;
    last_d    = last_q;
    ctx_out_d = ctx_out_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    abort_d   = 1'b0;
    iter_load = 1'b0;
    iter_dec  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.run_req && bus.start) begin
          if (bus.last_cp >= bus.base_cp) begin
            base_d    = bus.base_cp;
            last_d    = bus.last_cp;
            cp_d      = bus.base_cp;
            iter_load = 1'b1;
            state_d   = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        // Loss of start takes priority over stall.
        if (!bus.start) begin
          state_d = StIdle;
          abort_d = 1'b1;
          cp_d    = '0;
        end else if (!bus.stall) begin
          ctx_out_d = bus.ctx_in;
          valid_d   = 1'b1;
          if (cp_q != last_q) begin
            cp_d = cp_q + AddrW'(1);
          end else if (!iter_last) begin
            cp_d     = base_q;
            iter_dec = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      cp_q      <= '0;
      base_q    <= '0;
      last_q    <= '0;
      ctx_out_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cp_q      <= cp_d;
      base_q    <= base_d;
      last_q    <= last_d;
      ctx_out_q <= ctx_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.CP        = {{(CpW - AddrW){1'b0}}, cp_q};
  assign bus.ctx_out   = ctx_out_q;
  assign bus.ctx_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.abort     = abort_q;

endmodule

// File: tb/tb_agu_context_sequencer.sv
// Bench for agu_context_sequencer; it models the context cache as entry i holding the value i*3.
// Each expected word goes into a queue when a run is issued and comes off when ctx_valid is seen.
module tb_agu_context_sequencer;
  import agu_context_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [CtxW-1:0] cache [64];
  logic [CtxW-1:0] exp_q [$];

  agu_context_sequencer_if bus ();

  agu_context_sequencer u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  assign bus.ctx_in = cache[bus.CP[AddrW-1:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int b, input int l, input int n);
    int passes;
    passes = (n == 0) ? 1 : n;
    for (int p = 0; p < passes; p++)
      for (int i = b; i <= l; i++) exp_q.push_back(CtxW'(i * 3));
  endtask

  task automatic issue_run(input int b, input int l, input int n);
    bus.base_cp  = AddrW'(b);
    bus.last_cp  = AddrW'(l);
    bus.iter_cnt = IterW'(n);
    bus.run_req  = 1'b1;
    step();
    bus.run_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({bus.CP, bus.ctx_out, bus.ctx_valid, bus.busy, bus.done, bus.err, bus.abort} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: CP=%0d ctx_out=%0d v=%b busy=%b done=%b err=%b abort=%b, want all 0",
               bus.CP, bus.ctx_out, bus.ctx_valid, bus.busy, bus.done, bus.err, bus.abort);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [CtxW-1:0] e;
    int first_cyc;
    int done_cnt;
    exp_q.delete();
    push_range(4, 7, 2);
    issue_run(4, 7, 2);
    total++;
    if (bus.CP !== 16'd4 || bus.busy !== 1'b1 || bus.ctx_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_accept: CP=%0d busy=%b v=%b, want CP=4 busy=1 v=0",
               bus.CP, bus.busy, bus.ctx_valid);
    end
    first_cyc = -1;
    done_cnt  = 0;
    for (int c = 1; c <= 16; c++) begin
      // A request that arrives mid-run must be dropped.
      if (c == 3) begin
        bus.run_req = 1'b1;
        bus.base_cp = '0;
        bus.last_cp = '0;
      end else begin
        bus.run_req = 1'b0;
      end
      step();
      if (bus.done === 1'b1) done_cnt++;
      if (bus.ctx_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = c;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL basic_extra_word: got %0d, want no more words", bus.ctx_out);
        end else begin
          e = exp_q.pop_front();
          if (bus.ctx_out !== e || bus.done !== ((exp_q.size() == 0) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL basic_word: ctx_out=%0d done=%b, want %0d done=%b",
                     bus.ctx_out, bus.done, e, (exp_q.size() == 0));
          end
        end
      end
    end
    total++;
    if (first_cyc != 1 || exp_q.size() != 0 || done_cnt != 1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_summary: first=%0d left=%0d dones=%0d busy=%b, want 1 0 1 0",
               first_cyc, exp_q.size(), done_cnt, bus.busy);
    end
  endtask

  task automatic test_single();
    issue_run(10, 10, 0);
    total++;
    if (bus.CP !== 16'd10 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL single_accept: CP=%0d busy=%b, want 10 1", bus.CP, bus.busy);
    end
    step();
    total++;
    if (bus.ctx_valid !== 1'b1 || bus.ctx_out !== CtxW'(30) || bus.done !== 1'b1 ||
        bus.CP !== 16'd10) begin
      bad++;
      $display("FAIL single_word: v=%b ctx_out=%0d done=%b CP=%0d, want 1 30 1 10",
               bus.ctx_valid, bus.ctx_out, bus.done, bus.CP);
    end
    step();
    total++;
    if (bus.ctx_valid !== 1'b0 || bus.done !== 1'b0 || bus.CP !== 16'd10 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL single_after: v=%b done=%b CP=%0d busy=%b, want 0 0 10 0",
               bus.ctx_valid, bus.done, bus.CP, bus.busy);
    end
  endtask

  task automatic test_err();
    issue_run(9, 3, 1);
    total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.CP !== 16'd10) begin
      bad++;
      $display("FAIL err_pulse: err=%b busy=%b CP=%0d, want 1 0 10", bus.err, bus.busy, bus.CP);
    end
    step();
    total++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b busy=%b, want 0 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_stall();
    logic [CtxW-1:0] e;
    exp_q.delete();
    push_range(0, 3, 1);
    issue_run(0, 3, 1);
    for (int w = 0; w < 2; w++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (bus.ctx_valid !== 1'b1 || bus.ctx_out !== e) begin
        bad++;
        $display("FAIL stall_pre_word%0d: v=%b ctx_out=%0d, want 1 %0d", w, bus.ctx_valid, bus.ctx_out, e);
      end
    end
    bus.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      total++;
      if (bus.ctx_valid !== 1'b0 || bus.CP !== 16'd2 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: v=%b CP=%0d done=%b, want 0 2 0", s, bus.ctx_valid, bus.CP, bus.done);
      end
    end
    bus.stall = 1'b0;
    for (int w = 2; w < 4; w++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (bus.ctx_valid !== 1'b1 || bus.ctx_out !== e || bus.done !== ((w == 3) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL stall_post_word%0d: v=%b ctx_out=%0d done=%b, want 1 %0d %b",
                 w, bus.ctx_valid, bus.ctx_out, bus.done, e, (w == 3));
      end
    end
    step();
  endtask

  task automatic test_abort();
    logic [CtxW-1:0] e;
    exp_q.delete();
    push_range(20, 21, 1);
    issue_run(20, 30, 1);
    for (int w = 0; w < 2; w++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (bus.ctx_valid !== 1'b1 || bus.ctx_out !== e) begin
        bad++;
        $display("FAIL abort_word%0d: v=%b ctx_out=%0d, want 1 %0d", w, bus.ctx_valid, bus.ctx_out, e);
      end
    end
    bus.start = 1'b0;
    step();
    total++;
    if (bus.abort !== 1'b1 || bus.CP !== 16'd0 || bus.ctx_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse: abort=%b CP=%0d v=%b busy=%b done=%b, want 1 0 0 0 0",
               bus.abort, bus.CP, bus.ctx_valid, bus.busy, bus.done);
    end
    step();
    total++;
    if (bus.abort !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear: abort=%b done=%b, want 0 0", bus.abort, bus.done);
    end
    issue_run(0, 5, 1);
    total++;
    if (bus.busy !== 1'b0 || bus.CP !== 16'd0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL abort_nostart_req: busy=%b CP=%0d err=%b, want 0 0 0", bus.busy, bus.CP, bus.err);
    end
    bus.start = 1'b1;
    exp_q.delete();
    push_range(1, 2, 1);
    issue_run(1, 2, 1);
    total++;
    if (bus.busy !== 1'b1 || bus.CP !== 16'd1) begin
      bad++;
      $display("FAIL abort_restart: busy=%b CP=%0d, want 1 1", bus.busy, bus.CP);
    end
    for (int w = 0; w < 2; w++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (bus.ctx_valid !== 1'b1 || bus.ctx_out !== e || bus.done !== ((w == 1) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL restart_word%0d: v=%b ctx_out=%0d done=%b, want 1 %0d %b",
                 w, bus.ctx_valid, bus.ctx_out, bus.done, e, (w == 1));
      end
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    issue_run(0, 63, 1);
    step();
    step();
    step();
    total++;
    if (bus.CP !== 16'd3 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: CP=%0d busy=%b, want 3 1", bus.CP, bus.busy);
    end
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      step();
      total++;
      if ({bus.CP, bus.ctx_out, bus.ctx_valid, bus.busy, bus.done, bus.err, bus.abort} !== '0) begin
        bad++;
        $display("FAIL midrst_cycle%0d: CP=%0d ctx_out=%0d v=%b busy=%b done=%b abort=%b, want all 0",
                 r, bus.CP, bus.ctx_out, bus.ctx_valid, bus.busy, bus.done, bus.abort);
      end
    end
    rst_n = 1'b1;
    step();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.abort !== 1'b0 || bus.ctx_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after: busy=%b done=%b abort=%b v=%b, want 0 0 0 0",
               bus.busy, bus.done, bus.abort, bus.ctx_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) cache[i] = CtxW'(i * 3);
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.run_req  = 1'b0;
    bus.base_cp  = '0;
    bus.last_cp  = '0;
    bus.iter_cnt = '0;
    bus.stall    = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_err();
    test_stall();
    test_abort();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
